// File: rtl/uart_result_tx.sv
// uart_result_tx: converts a binary solver result to fixed-width, zero-padded
// ASCII decimal and sends it most significant digit first over an 8E1 UART
// line (start, 8 data bits LSB first, even parity, stop).
module uart_result_tx #(
   parameter int CLKS_PER_BIT = 1250,
   parameter int VAL_W        = 7,
   parameter int NUM_DIGITS   = 2
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [VAL_W-1:0] value,
   output logic             busy,
   output logic             done,
   output logic             uart_rxd_out
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CONVERT = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_START   = 3'd3;
   localparam logic [2:0] S_DATA    = 3'd4;
   localparam logic [2:0] S_PARITY  = 3'd5;
   localparam logic [2:0] S_STOP    = 3'd6;
   localparam logic [2:0] S_DONE    = 3'd7;

   // 10^k for 0 <= k <= NUM_DIGITS; fixed loop bound keeps it synthesizable
   // when k is a runtime digit index.
   function automatic int pow10(input int k);
      int p;
      p = 1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i < k) p = p * 10;
      end
      return p;
   endfunction

   // Decimal digit to ASCII, clamped to '9' so an out-of-range count can
   // never produce a non-digit character.
   function automatic logic [7:0] digit_ascii(input logic [3:0] d);
      logic [3:0] c;
      c = (d > 4'd9) ? 4'd9 : d;
      return 8'h30 + {4'h0, c};
   endfunction

   localparam int SAT_LIMIT = pow10(NUM_DIGITS);

   logic [2:0]        state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [DIG_W-1:0]  dig_idx;
   logic [3:0]        dig_cnt;
   logic [DIG_W-1:0]  char_idx;

   logic [VAL_W-1:0]  rem;
   logic [7:0]        digit_r [NUM_DIGITS];
   logic [7:0]        char_sr;
   logic              parity_r;

   logic [31:0]       rem_ext;
   logic [31:0]       cur_pow;
   logic [31:0]       sat_lim;
   logic              baud_end;

   assign rem_ext  = 32'(rem);
   assign cur_pow  = 32'(pow10(int'(dig_idx)));
   assign sat_lim  = 32'(SAT_LIMIT);
   assign baud_end = (baud_cnt == BAUD_LAST);

   // Control FSM, bit/baud counters and the registered serial line.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         uart_rxd_out <= 1'b1;
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         dig_idx      <= '0;
         dig_cnt      <= '0;
         char_idx     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_CONVERT;
                  busy    <= 1'b1;
                  dig_idx <= DIG_LAST;
                  dig_cnt <= '0;
               end
            end
            S_CONVERT: begin
               if (rem_ext >= sat_lim) begin
                  state    <= S_LOAD;
                  char_idx <= DIG_LAST;
               end else if (rem_ext >= cur_pow) begin
                  dig_cnt <= dig_cnt + 4'd1;
               end else begin
                  dig_cnt <= '0;
                  if (dig_idx == '0) begin
                     state    <= S_LOAD;
                     char_idx <= DIG_LAST;
                  end else begin
                     dig_idx <= dig_idx - DIG_W'(1);
                  end
               end
            end
            S_LOAD: begin
               state        <= S_START;
               baud_cnt     <= '0;
               bit_cnt      <= '0;
               uart_rxd_out <= 1'b0;
            end
            S_START: begin
               if (baud_end) begin
                  baud_cnt     <= '0;
                  state        <= S_DATA;
                  uart_rxd_out <= char_sr[0];
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            S_DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state        <= S_PARITY;
                     uart_rxd_out <= parity_r;
                  end else begin
                     uart_rxd_out <= char_sr[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            S_PARITY: begin
               if (baud_end) begin
                  baud_cnt     <= '0;
                  state        <= S_STOP;
                  uart_rxd_out <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            S_STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (char_idx == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     char_idx <= char_idx - DIG_W'(1);
                     state    <= S_LOAD;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Datapath: value latch, digit extraction, character and parity staging.
   always_ff @(posedge sysclk) begin
      case (state)
         S_IDLE: begin
            if (start) rem <= value;
         end
         S_CONVERT: begin
            if (rem_ext >= sat_lim) begin
               for (int i = 0; i < NUM_DIGITS; i++) begin
                  digit_r[i] <= digit_ascii(4'd9);
               end
            end else if (rem_ext >= cur_pow) begin
               rem <= rem - cur_pow[VAL_W-1:0];
            end else begin
               digit_r[dig_idx] <= digit_ascii(dig_cnt);
            end
         end
         S_LOAD: begin
            char_sr  <= digit_r[char_idx];
            parity_r <= ^digit_r[char_idx];
         end
         S_DATA: begin
            if (baud_end) char_sr <= {1'b0, char_sr[7:1]};
         end
         default: begin
         end
      endcase
   end

endmodule
